ahb_stream_writer: RTL and testbench

- Parametrised AHB-Lite write master that takes cipher blocks from the AES datapath and writes them to SRAM as INCR bursts at consecutive addresses.
- Buffers blocks in a small FIFO, drops blocks flagged bad, and honours HREADY wait states.
- Can append one trailer beat (e.g. the key) after the final data block.

---
 rtl/ahb_stream_writer.sv | 191 +++++++++++++++++++
 tb/tb_ahb_stream_writer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_stream_writer.sv
// AHB-Lite INCR-burst write master: buffers AES output blocks, drops bad ones,
// writes the rest to consecutive SRAM addresses and optionally appends a trailer beat.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | waiting for start
// S_RUN      | accepting input beats, issuing data address/data phases
// S_WAIT_TRL | all data written, waiting for trailer_valid or abort
// S_TRL_ADDR | trailer address phase (NONSEQ)
// S_TRL_DATA | trailer data phase
// S_FIN      | one-cycle done pulse
module ahb_stream_writer #(
    parameter int DATA_W     = 128,
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int WRAP_BITS  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              trailer_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_err,
    input  logic              in_last,
    input  logic              trailer_valid,
    input  logic [DATA_W-1:0] trailer_data,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [15:0]       beats,
    input  logic              HREADY,
    output logic              HWRITE,
    output logic [1:0]        HTRANS,
    output logic [2:0]        HBURST,
    output logic [2:0]        HSIZE,
    output logic [ADDR_W-1:0] HADDR,
    output logic [DATA_W-1:0] HWDATA
);
    localparam int STEP  = DATA_W / 8;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [1:0] TR_IDLE   = 2'd0;
    localparam logic [1:0] TR_BUSY   = 2'd1;
    localparam logic [1:0] TR_NONSEQ = 2'd2;
    localparam logic [1:0] TR_SEQ    = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_RUN, S_WAIT_TRL, S_TRL_ADDR, S_TRL_DATA, S_FIN
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    fifo_cnt;
    logic              fifo_full, fifo_empty;
    logic              accept, push, pop;

    logic [ADDR_W-1:0]    addr_q, addr_inc;
    logic [WRAP_BITS-1:0] low_inc;
    logic                 restart;
    logic                 trl_en_q, last_seen, dphase_q;
    logic [1:0]           prev_trans, htrans_c;
    logic [DATA_W-1:0]    wdata_q;
    logic [15:0]          beats_q;
    logic                 dphase_done, run_exit;

    assign fifo_full   = (fifo_cnt == (PTR_W+1)'(FIFO_DEPTH));
    assign fifo_empty  = (fifo_cnt == '0);
    assign in_ready    = (state == S_RUN) && !fifo_full && !last_seen;
    assign accept      = in_valid && in_ready;
    assign push        = accept && !in_err;
    assign pop         = (state == S_RUN) && !fifo_empty && HREADY;
    assign dphase_done = dphase_q && HREADY;
    assign run_exit    = last_seen && fifo_empty && (!dphase_q || HREADY);

    // Only the low WRAP_BITS advance; landing on a 1 KB boundary or wrapping forces a new NONSEQ.
    always_comb begin
        low_inc  = addr_q[WRAP_BITS-1:0] + WRAP_BITS'(STEP);
        addr_inc = addr_q;
        addr_inc[WRAP_BITS-1:0] = low_inc;
    end

    assign restart = (addr_inc[9:0] == 10'd0) || (low_inc == '0);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (start) state_nxt = S_RUN;
            S_RUN:      if (run_exit) state_nxt = trl_en_q ? S_WAIT_TRL : S_FIN;
            S_WAIT_TRL: begin
                if (trailer_valid)  state_nxt = S_TRL_ADDR;
                else if (abort)     state_nxt = S_FIN;
            end
            S_TRL_ADDR: if (HREADY) state_nxt = S_TRL_DATA;
            S_TRL_DATA: if (HREADY) state_nxt = S_FIN;
            S_FIN:      state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // BUSY only directly after an active beat; a second empty cycle falls back to IDLE.
    always_comb begin
        htrans_c = TR_IDLE;
        case (state)
            S_RUN: begin
                if (!fifo_empty)
                    htrans_c = (prev_trans == TR_IDLE) ? TR_NONSEQ : TR_SEQ;
                else if (!last_seen && prev_trans[1])
                    htrans_c = TR_BUSY;
            end
            S_TRL_ADDR: htrans_c = TR_NONSEQ;
            default:    htrans_c = TR_IDLE;
        endcase
    end

    assign HTRANS = htrans_c;
    assign HWRITE = (htrans_c != TR_IDLE);
    assign HADDR  = addr_q;
    assign HWDATA = wdata_q;
    assign HBURST = 3'b001;
    assign HSIZE  = 3'($clog2(STEP));
    assign busy   = (state != S_IDLE);
    assign done   = (state == S_FIN);
    assign beats  = beats_q;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            addr_q     <= '0;
            trl_en_q   <= 1'b0;
            last_seen  <= 1'b0;
            dphase_q   <= 1'b0;
            prev_trans <= TR_IDLE;
            wdata_q    <= '0;
            beats_q    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
                default: ;
            endcase

            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr_q     <= base_addr;
                        trl_en_q   <= trailer_en;
                        last_seen  <= 1'b0;
                        dphase_q   <= 1'b0;
                        prev_trans <= TR_IDLE;
                    end
                end
                S_RUN: begin
                    if (accept && in_last) last_seen <= 1'b1;
                    if (HREADY) begin
                        dphase_q   <= pop;
                        prev_trans <= (pop && restart) ? TR_IDLE : htrans_c;
                    end
                    if (pop) begin
                        wdata_q <= fifo_mem[rd_ptr];
                        addr_q  <= addr_inc;
                    end
                end
                S_WAIT_TRL: if (trailer_valid) wdata_q <= trailer_data;
                S_TRL_ADDR: if (HREADY) dphase_q <= 1'b1;
                S_TRL_DATA: if (HREADY) dphase_q <= 1'b0;
                default: ;
            endcase

            if (state == S_IDLE && start) beats_q <= '0;
            else if (dphase_done)         beats_q <= beats_q + 16'd1;
        end
    end
endmodule

// File: tb/tb_ahb_stream_writer.sv
// Self-checking bench for ahb_stream_writer: table of jobs, scoreboard of expected writes.
module tb_ahb_stream_writer;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [31:0]  base_addr;
    logic         trailer_en;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_err;
    logic         in_last;
    logic         trailer_valid;
    logic [127:0] trailer_data;
    logic         abort;
    logic         busy;
    logic         done;
    logic [15:0]  beats;
    logic         HREADY;
    logic         HWRITE;
    logic [1:0]   HTRANS;
    logic [2:0]   HBURST;
    logic [2:0]   HSIZE;
    logic [31:0]  HADDR;
    logic [127:0] HWDATA;

    ahb_stream_writer dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .trailer_en(trailer_en), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_err(in_err), .in_last(in_last),
        .trailer_valid(trailer_valid), .trailer_data(trailer_data), .abort(abort),
        .busy(busy), .done(done), .beats(beats), .HREADY(HREADY), .HWRITE(HWRITE),
        .HTRANS(HTRANS), .HBURST(HBURST), .HSIZE(HSIZE), .HADDR(HADDR), .HWDATA(HWDATA)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] base;
        int          nbeats;
        logic [7:0]  err_mask;
        bit          stall;
        int          trl;        // 0 none, 1 trailer key, 2 abort
        int          exp_beats;
    } job_t;

    typedef struct {
        logic [31:0]  addr;
        logic [127:0] data;
        logic [1:0]   trans;
    } exp_t;

    localparam logic [127:0] KEY = {16{8'hA5}};

    exp_t   exp_q[$];
    job_t   jobs[9];
    int     n_chk = 0;
    int     n_fail = 0;
    int     cyc = 0;
    int     last_dp_cyc = 0;
    bit     sb_off = 1'b0;
    logic [31:0] mdl_next_addr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bus monitor: samples mid-low-phase, pairs each accepted address phase with its data phase.
    initial begin
        bit           pend, prev_pend, prev_hready, prev_act;
        logic [31:0]  pend_addr, prev_haddr;
        logic [1:0]   pend_trans, prev_htrans;
        logic [127:0] prev_hwdata;
        exp_t         e;
        pend = 0; prev_pend = 0; prev_hready = 1; prev_act = 0;
        forever begin
            @(negedge clk); #2;
            if (rst || sb_off) begin
                pend = 0; prev_pend = 0; prev_hready = 1; prev_act = 0;
            end else begin
                if (!prev_hready && prev_act) begin
                    check("stall_haddr_hold", HADDR, prev_haddr);
                    check("stall_htrans_hold", HTRANS, prev_htrans);
                end
                if (prev_pend) check("stall_hwdata_hold", HWDATA, prev_hwdata);
                prev_pend = pend && !HREADY;
                if (pend && HREADY) begin
                    check("sb_nonempty", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("wr_addr", pend_addr, e.addr);
                        check("wr_trans", pend_trans, e.trans);
                        check("wr_data", HWDATA, e.data);
                    end
                    pend = 0;
                    last_dp_cyc = cyc;
                end
                if (HTRANS[1]) check("hwrite", HWRITE, 1);
                if (HTRANS[1] && HREADY) begin
                    pend = 1; pend_addr = HADDR; pend_trans = HTRANS;
                end
                prev_hready = HREADY; prev_act = HTRANS[1];
                prev_haddr = HADDR; prev_htrans = HTRANS; prev_hwdata = HWDATA;
            end
        end
    end

    task automatic feed(input job_t j);
        logic [31:0]  a, na;
        logic [127:0] d;
        bit           nseq, ok;
        int           errs;
        a = j.base; nseq = 1; errs = 0;
        for (int i = 0; i < j.nbeats; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            in_valid = 1; in_data = d; in_err = j.err_mask[i]; in_last = (i == j.nbeats - 1);
            ok = 0;
            for (int k = 0; k < 100 && !ok; k++) begin
                if (in_ready) ok = 1;
                else @(negedge clk);
            end
            check("in_ready_wait", ok, 1);
            if (!j.err_mask[i]) begin
                exp_q.push_back('{a, d, (nseq || errs >= 2) ? 2'd2 : 2'd3});
                na = {a[31:16], a[15:0] + 16'h0010};
                nseq = (na[9:0] == 10'd0) || (na[15:0] == 16'd0);
                a = na; errs = 0;
            end else begin
                errs++;
            end
            @(negedge clk);
        end
        in_valid = 0; in_err = 0; in_last = 0;
        mdl_next_addr = a;
    endtask

    task automatic stall(input job_t j);
        if (j.stall) begin
            repeat (3) @(negedge clk);
            HREADY = 0;
            repeat (3) @(negedge clk);
            HREADY = 1;
        end
    endtask

    task automatic run_job(input job_t j);
        bit got;
        start = 1; base_addr = j.base; trailer_en = (j.trl != 0);
        @(negedge clk);
        start = 0;
        check("busy_run", busy, 1);
        fork
            feed(j);
            stall(j);
        join
        if (j.trl == 1) begin
            exp_q.push_back('{mdl_next_addr, KEY, 2'd2});
            trailer_valid = 1; trailer_data = KEY;
        end else if (j.trl == 2) begin
            abort = 1;
        end
        got = 0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (done) got = 1;
        end
        check("done_seen", got, 1);
        check("beats", beats, j.exp_beats);
        if (j.trl == 0 && j.exp_beats != 0) check("done_latency", cyc, last_dp_cyc + 1);
        trailer_valid = 0; abort = 0;
        @(negedge clk);
        check("done_pulse", done, 0);
        check("busy_idle", busy, 0);
        check("sb_drained", exp_q.size(), 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_htrans"}, HTRANS, 0);
        check({tag, "_haddr"}, HADDR, 0);
        check({tag, "_hwdata"}, HWDATA, 0);
        check({tag, "_hwrite"}, HWRITE, 0);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_beats"}, beats, 0);
        check({tag, "_hsize"}, HSIZE, 3'd4);
        check({tag, "_hburst"}, HBURST, 3'b001);
    endtask

    initial begin
        jobs[0] = '{32'h2000_0000, 4, 8'h00, 1'b0, 0, 4};
        jobs[1] = '{32'h2000_0100, 5, 8'h02, 1'b0, 0, 4};
        jobs[2] = '{32'h2000_0200, 6, 8'h00, 1'b1, 0, 6};
        jobs[3] = '{32'h1000_FFE0, 3, 8'h00, 1'b0, 0, 3};
        jobs[4] = '{32'h2000_0300, 2, 8'h00, 1'b0, 1, 3};
        jobs[5] = '{32'h2000_0400, 2, 8'h00, 1'b0, 2, 2};
        jobs[6] = '{32'h2000_0500, 3, 8'h07, 1'b0, 0, 0};
        jobs[7] = '{32'h2000_03E0, 4, 8'h00, 1'b0, 0, 4};
        jobs[8] = '{32'h2000_0600, 1, 8'h01, 1'b0, 1, 1};

        rst = 1; start = 0; base_addr = '0; trailer_en = 0;
        in_valid = 0; in_data = '0; in_err = 0; in_last = 0;
        trailer_valid = 0; trailer_data = '0; abort = 0; HREADY = 1;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst = 0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_job(jobs[i]);

        // Reset in the middle of a burst, then a clean job must see an empty FIFO.
        sb_off = 1;
        start = 1; base_addr = 32'h2000_0700; trailer_en = 0;
        @(negedge clk);
        start = 0;
        in_valid = 1; in_data = {4{32'hDEAD_BEEF}}; in_err = 0; in_last = 0;
        repeat (3) @(negedge clk);
        in_valid = 0;
        check("pre_rst_active", HTRANS[1], 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check_zero_outputs("midrst");
        exp_q.delete();
        @(negedge clk);
        sb_off = 0;
        run_job(jobs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
